snake_move_module: RTL and testbench

Owns snake geometry for the greedy-snake game: turns direction-key pulses into a stepping snake, tracks up to MAX_LEN segments, and detects wall and self collisions. It is the other end of the game-control interface: it consumes Game_status and produces Hit_wall_sig / Hit_body_sig. Geometry is exposed to the VGA renderer through a registered segment read port.

---
 rtl/snake_move_module.sv | 207 ++++++++++++++++++++
 tb/tb_snake_move_module.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_module.sv
// Snake geometry engine: steps the snake on a timer, tracks up to MAX_LEN segments, flags wall/body hits.
// Define SNAKE_WRAP_EN to make the grid edges wrap around instead of raising Hit_wall_sig.
module snake_move_module #(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int X_W         = 6,
  parameter int Y_W         = 5,
  parameter int MAX_LEN     = 16,
  parameter int STEP_CYCLES = 12_500_000
) (
  input  logic                       Clk_50mhz,
  input  logic                       Rst_n,
  input  logic                       Key_left,
  input  logic                       Key_right,
  input  logic                       Key_up,
  input  logic                       Key_down,
  input  logic [2:0]                 Game_status,
  input  logic                       Grow_pulse,
  input  logic [$clog2(MAX_LEN)-1:0] Seg_idx,
  output logic [X_W-1:0]             Seg_x,
  output logic [Y_W-1:0]             Seg_y,
  output logic                       Seg_valid,
  output logic [X_W-1:0]             Head_x,
  output logic [Y_W-1:0]             Head_y,
  output logic [$clog2(MAX_LEN):0]   Snake_len,
  output logic                       Step_tick,
  output logic                       Hit_wall_sig,
  output logic                       Hit_body_sig
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = IDX_W + 1;
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [X_W-1:0]   X_MAX    = X_W'(GRID_W - 1);
  localparam logic [X_W-1:0]   X_MID    = X_W'(GRID_W / 2);
  localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GRID_H - 1);
  localparam logic [Y_W-1:0]   Y_MID    = Y_W'(GRID_H / 2);
  localparam logic [Y_W-1:0]   Y_ONE    = Y_W'(1);
  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(3);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  logic [X_W-1:0]   r_seg_x [MAX_LEN];
  logic [Y_W-1:0]   r_seg_y [MAX_LEN];
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  dir_t             r_dir;
  dir_t             r_next_dir;
  logic             r_grow;
  logic             r_hit_wall;
  logic             r_hit_body;

  logic             w_play;
  logic             w_start;
  logic             w_hit;
  logic             w_tick;
  logic             w_grow_eff;
  dir_t             w_key_dir;
  logic [X_W-1:0]   w_nx;
  logic [Y_W-1:0]   w_ny;
  logic             w_edge;
  logic             w_wall;
  logic             w_body;
  logic [LEN_W-1:0] w_len_m1;

  // Initial body lies horizontally to the left of the centre cell.
  function automatic logic [X_W-1:0] init_x(input int i);
    return (i < 3) ? X_MID - X_W'(i) : '0;
  endfunction

  function automatic logic [Y_W-1:0] init_y(input int i);
    return (i < 3) ? Y_MID : '0;
  endfunction

  assign w_play     = (Game_status == 3'b010);
  assign w_start    = (Game_status == 3'b001);
  assign w_hit      = r_hit_wall | r_hit_body;
  assign w_tick     = w_play & ~w_hit & (r_cnt == CNT_LAST);
  assign w_grow_eff = r_grow | Grow_pulse;
  assign w_len_m1   = r_len - LEN_ONE;
  assign w_wall     = w_edge & ~WRAP_EN;

  // A reversing key is dropped before priority selection; this cycle's key counts at a step.
  always_comb begin
    w_key_dir = r_next_dir;
    if (Key_up && r_dir != DIR_DOWN)          w_key_dir = DIR_UP;
    else if (Key_down && r_dir != DIR_UP)     w_key_dir = DIR_DOWN;
    else if (Key_left && r_dir != DIR_RIGHT)  w_key_dir = DIR_LEFT;
    else if (Key_right && r_dir != DIR_LEFT)  w_key_dir = DIR_RIGHT;
  end

  always_comb begin
    w_nx   = r_seg_x[0];
    w_ny   = r_seg_y[0];
    w_edge = 1'b0;
    case (w_key_dir)
      DIR_UP: begin
        w_edge = (r_seg_y[0] == '0);
        w_ny   = w_edge ? Y_MAX : r_seg_y[0] - Y_ONE;
      end
      DIR_DOWN: begin
        w_edge = (r_seg_y[0] == Y_MAX);
        w_ny   = w_edge ? '0 : r_seg_y[0] + Y_ONE;
      end
      DIR_LEFT: begin
        w_edge = (r_seg_x[0] == '0);
        w_nx   = w_edge ? X_MAX : r_seg_x[0] - X_ONE;
      end
      default: begin
        w_edge = (r_seg_x[0] == X_MAX);
        w_nx   = w_edge ? '0 : r_seg_x[0] + X_ONE;
      end
    endcase
  end

  // The tail cell only blocks when growing, otherwise it vacates on this step.
  always_comb begin
    w_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (r_seg_x[i] == w_nx && r_seg_y[i] == w_ny &&
          ((LEN_W'(i) < w_len_m1) || (LEN_W'(i) == w_len_m1 && w_grow_eff)))
        w_body = 1'b1;
    end
  end

  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= init_x(i);
        r_seg_y[i] <= init_y(i);
      end
      r_len      <= LEN_INIT;
      r_cnt      <= '0;
      r_dir      <= DIR_RIGHT;
      r_next_dir <= DIR_RIGHT;
      r_grow     <= 1'b0;
      r_hit_wall <= 1'b0;
      r_hit_body <= 1'b0;
    end else if (w_start) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= init_x(i);
        r_seg_y[i] <= init_y(i);
      end
      r_len      <= LEN_INIT;
      r_cnt      <= '0;
      r_dir      <= DIR_RIGHT;
      r_next_dir <= DIR_RIGHT;
      r_grow     <= 1'b0;
      r_hit_wall <= 1'b0;
      r_hit_body <= 1'b0;
    end else if (w_play) begin
      r_cnt      <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
      r_next_dir <= w_key_dir;
      r_grow     <= w_grow_eff;
      if (w_tick) begin
        r_dir  <= w_key_dir;
        r_grow <= 1'b0;
        if (w_wall) begin
          r_hit_wall <= 1'b1;
        end else if (w_body) begin
          r_hit_body <= 1'b1;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            r_seg_x[i] <= r_seg_x[i-1];
            r_seg_y[i] <= r_seg_y[i-1];
          end
          r_seg_x[0] <= w_nx;
          r_seg_y[0] <= w_ny;
          if (w_grow_eff && r_len < LEN_MAX) r_len <= r_len + LEN_ONE;
        end
      end
    end
  end

  // Renderer read port: one cycle from Seg_idx to data.
  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      Seg_x     <= '0;
      Seg_y     <= '0;
      Seg_valid <= 1'b0;
    end else begin
      Seg_x     <= r_seg_x[Seg_idx];
      Seg_y     <= r_seg_y[Seg_idx];
      Seg_valid <= ({1'b0, Seg_idx} < r_len);
    end
  end

  assign Head_x       = r_seg_x[0];
  assign Head_y       = r_seg_y[0];
  assign Snake_len    = r_len;
  assign Step_tick    = w_tick;
  assign Hit_wall_sig = r_hit_wall;
  assign Hit_body_sig = r_hit_body;

endmodule

// File: tb/tb_snake_move_module.sv
// Directed bench for snake_move_module on an 8x8 grid, MAX_LEN=4, four clocks per step.
module tb_snake_move_module;

  localparam int GW = 8;
  localparam int GH = 8;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int ML = 4;
  localparam int SC = 4;

  localparam logic [2:0] ST_START = 3'b001;
  localparam logic [2:0] ST_PLAY  = 3'b010;
  localparam logic [2:0] ST_END   = 3'b100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          kl = 1'b0, kr = 1'b0, ku = 1'b0, kd = 1'b0;
  logic [2:0]    status = ST_START;
  logic          grow = 1'b0;
  logic [1:0]    seg_idx = '0;
  logic [XW-1:0] seg_x, head_x;
  logic [YW-1:0] seg_y, head_y;
  logic          seg_valid, step_tick, hit_wall, hit_body;
  logic [2:0]    snake_len;

  int n_checks = 0;
  int n_errors = 0;

  snake_move_module #(
    .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .MAX_LEN(ML), .STEP_CYCLES(SC)
  ) dut (
    .Clk_50mhz(clk), .Rst_n(rst_n),
    .Key_left(kl), .Key_right(kr), .Key_up(ku), .Key_down(kd),
    .Game_status(status), .Grow_pulse(grow), .Seg_idx(seg_idx),
    .Seg_x(seg_x), .Seg_y(seg_y), .Seg_valid(seg_valid),
    .Head_x(head_x), .Head_y(head_y), .Snake_len(snake_len),
    .Step_tick(step_tick), .Hit_wall_sig(hit_wall), .Hit_body_sig(hit_body)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic g);
    ku = u; kd = d; kl = l; kr = r; grow = g;
    tick();
    ku = 1'b0; kd = 1'b0; kl = 1'b0; kr = 1'b0; grow = 1'b0;
  endtask

  // START for one edge, then PLAY: the next cycle is PLAY cycle 0
  task automatic restart();
    status = ST_START;
    tick();
    status = ST_PLAY;
  endtask

  // Grow to 4, then up, left; leaves the bench in PLAY cycle 12 with head (4,3)
  task automatic build_hook();
    restart();
    pulse(0, 0, 0, 0, 1);
    run(3);
    chk("hook_len4", snake_len, 4);
    pulse(1, 0, 0, 0, 0);
    run(3);
    chk("hook_up_y", head_y, 3);
    pulse(0, 0, 1, 0, 0);
    run(3);
    chk("hook_left_x", head_x, 4);
  endtask

  initial begin
    int ticks;

    // asynchronous reset, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_head_x", head_x, 4);
    chk("rst_head_y", head_y, 4);
    chk("rst_len", snake_len, 3);
    chk("rst_hits", {hit_wall, hit_body}, 0);
    chk("rst_tick", step_tick, 0);
    chk("rst_seg_port", {seg_x, seg_y, seg_valid}, 0);
    #10 rst_n = 1'b1;
    tick();

    // two steps in eight PLAY cycles
    status  = ST_PLAY;
    seg_idx = 2'd1;
    ticks   = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (step_tick) ticks++;
    end
    chk("two_ticks", ticks, 2);
    chk("t1_head_x", head_x, 6);
    chk("t1_head_y", head_y, 4);
    chk("t1_len", snake_len, 3);
    status = ST_END;
    tick();
    chk("t1_seg1_x", seg_x, 5);
    chk("t1_seg1_y", seg_y, 4);
    chk("t1_seg1_valid", seg_valid, 1);
    run(6);
    chk("end_freeze_x", head_x, 6);

    // right wall on the fourth step
    restart();
    run(15);
    chk("wall_tick", step_tick, 1);
    chk("wall_pre", hit_wall, 0);
    chk("wall_pre_x", head_x, 7);
    tick();
    chk("wall_hit", hit_wall, 1);
    chk("wall_hold_x", head_x, 7);
    chk("wall_hold_y", head_y, 4);
    run(8);
    chk("wall_sticky", hit_wall, 1);
    chk("wall_nomove_x", head_x, 7);
    status = ST_START;
    tick();
    chk("start_clr_wall", hit_wall, 0);
    chk("start_head_x", head_x, 4);
    chk("start_len", snake_len, 3);

    // reset mid-step restores state without a clock edge
    status = ST_PLAY;
    run(6);
    chk("mid_pre_x", head_x, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x", head_x, 4);
    chk("mid_rst_tick", step_tick, 0);
    tick();
    rst_n = 1'b1;

    // opposite key ignored; up beats left
    restart();
    pulse(0, 0, 1, 0, 0);
    run(3);
    chk("opp_ignored_x", head_x, 5);
    chk("opp_ignored_y", head_y, 4);
    pulse(1, 0, 1, 0, 0);
    run(3);
    chk("up_wins_x", head_x, 5);
    chk("up_wins_y", head_y, 3);

    // growth capped at MAX_LEN
    restart();
    pulse(0, 0, 0, 0, 1);
    run(3);
    chk("grow_len4", snake_len, 4);
    pulse(0, 0, 0, 0, 1);
    run(3);
    chk("grow_cap", snake_len, 4);
    chk("grow_head_x", head_x, 6);
    run(4);
    chk("grow_after_len", snake_len, 4);
    chk("grow_after_x", head_x, 7);
    seg_idx = 2'd3;
    status  = ST_END;
    tick();
    chk("grow_seg3_valid", seg_valid, 1);
    chk("grow_seg3_x", seg_x, 4);

    // tail chase into the vacating tail
    build_hook();
    pulse(0, 1, 0, 0, 0);
    run(3);
    chk("chase_nohit", hit_body, 0);
    chk("chase_head_x", head_x, 4);
    chk("chase_head_y", head_y, 4);

    // same cell while growing: key and grow in the tick cycle apply
    build_hook();
    run(3);
    chk("grow_hit_tick", step_tick, 1);
    pulse(0, 1, 0, 0, 1);
    chk("body_hit", hit_body, 1);
    chk("body_hold_y", head_y, 3);
    chk("body_nowall", hit_wall, 0);
    run(8);
    chk("body_sticky", hit_body, 1);
    chk("body_nomove_y", head_y, 3);

`ifdef SNAKE_WRAP_EN
    restart();
    run(16);
    chk("wrap_head_x", head_x, 0);
    chk("wrap_nowall", hit_wall, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
